// File: rtl/space_inv_pkg.sv
// Shared definitions for the space-invaders video blocks: march FSM states
// and 640x480 raster limits.
package space_inv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MARCH   = 2'd1,
        LANDED  = 2'd2,
        CLEARED = 2'd3
    } state_t;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned H_LAST   = H_ACTIVE - 1;
    localparam int unsigned V_LAST   = V_ACTIVE - 1;

endpackage

// File: rtl/alien_march_controller_col_edge_finder.sv
// Combinational scan of the column alive mask: outermost living columns,
// living-column count and an any-alive flag.
module col_edge_finder #(
    parameter int unsigned N_COLS = 8,
    localparam int unsigned CW = (N_COLS > 1) ? $clog2(N_COLS) : 1,
    localparam int unsigned PW = $clog2(N_COLS + 1)
) (
    input  logic [N_COLS-1:0] col_alive,
    output logic [CW-1:0]     lcol,
    output logic [CW-1:0]     rcol,
    output logic [PW-1:0]     popcount,
    output logic              any_alive
);

    always_comb begin
        lcol     = '0;
        rcol     = '0;
        popcount = '0;
        // Ascending scan keeps the highest hit for rcol; the mirrored index
        // keeps the lowest hit for lcol.
        for (int unsigned i = 0; i < N_COLS; i++) begin
            if (col_alive[i]) begin
                rcol     = CW'(i);
                popcount = popcount + PW'(1);
            end
            if (col_alive[N_COLS-1-i]) begin
                lcol = CW'(N_COLS - 1 - i);
            end
        end
    end

    assign any_alive = |col_alive;

endmodule

// File: rtl/alien_march_controller.sv
// Alien formation march sequencer: frame-timed sideways steps, edge drops
// with reversal, speed-up as columns die, landing and wave-clear flags.
module alien_march_controller
    import space_inv_pkg::*;
#(
    parameter int unsigned N_COLS         = 8,
    parameter int unsigned COL_PITCH      = 40,
    parameter int unsigned ALIEN_W        = 31,
    parameter int unsigned FORM_H         = 100,
    parameter int unsigned START_X        = 135,
    parameter int unsigned START_Y        = 120,
    parameter int unsigned STEP_X         = 4,
    parameter int unsigned STEP_Y         = 16,
    parameter int unsigned X_MIN          = 4,
    parameter int unsigned X_MAX          = 634,
    parameter int unsigned LAND_Y         = 440,
    parameter int unsigned PERIOD_MIN     = 2,
    parameter int unsigned PERIOD_PER_COL = 2
) (
    input  logic              Pclk,
    input  logic              rst_n,
    input  logic [9:0]        xx,
    input  logic [9:0]        yy,
    input  logic              start,
    input  logic              enable,
    input  logic [N_COLS-1:0] col_alive,
    output logic [9:0]        form_x,
    output logic [9:0]        form_y,
    output logic              dir,
    output logic              step,
    output logic              drop,
    output logic              landed,
    output logic              cleared
);

    localparam int unsigned CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int unsigned PW = $clog2(N_COLS + 1);

    localparam logic [10:0] PITCH11   = 11'(COL_PITCH);
    localparam logic [10:0] WIDTH11   = 11'(ALIEN_W);
    localparam logic [10:0] FORM_H11  = 11'(FORM_H);
    localparam logic [10:0] STEP_X11  = 11'(STEP_X);
    localparam logic [10:0] STEP_Y11  = 11'(STEP_Y);
    localparam logic [10:0] LEFT_LIM  = 11'(X_MIN + STEP_X);
    localparam logic [10:0] X_MAX11   = 11'(X_MAX);
    localparam logic [10:0] LAND_Y11  = 11'(LAND_Y);

    state_t      state, state_n;
    logic [7:0]  frame_cnt, frame_cnt_n;
    logic [9:0]  form_x_n, form_y_n;
    logic        dir_n, step_n, drop_n, landed_n, cleared_n;

    logic [CW-1:0] lcol, rcol;
    logic [PW-1:0] popcount;
    logic          any_alive;

    col_edge_finder #(.N_COLS(N_COLS)) u_edges (
        .col_alive (col_alive),
        .lcol      (lcol),
        .rcol      (rcol),
        .popcount  (popcount),
        .any_alive (any_alive)
    );

    logic        tick;
    logic [7:0]  period;
    logic [7:0]  cnt_inc;
    logic [10:0] left_edge, right_edge, new_y;
    logic        want_drop, will_land;

    assign tick       = (xx == 10'(H_LAST)) && (yy == 10'(V_LAST));
    assign period     = 8'(PERIOD_MIN) + 8'(popcount) * 8'(PERIOD_PER_COL);
    assign cnt_inc    = frame_cnt + 8'd1;
    assign left_edge  = {1'b0, form_x} + 11'(lcol) * PITCH11;
    assign right_edge = {1'b0, form_x} + 11'(rcol) * PITCH11 + WIDTH11;
    assign want_drop  = dir ? (right_edge + STEP_X11 > X_MAX11)
                            : (left_edge < LEFT_LIM);
    assign new_y      = {1'b0, form_y} + STEP_Y11;
    assign will_land  = (new_y + FORM_H11) >= LAND_Y11;

    always_ff @(posedge Pclk) begin
        if (!rst_n) begin
            state     <= IDLE;
            frame_cnt <= '0;
            form_x    <= 10'(START_X);
            form_y    <= 10'(START_Y);
            dir       <= 1'b1;
            step      <= 1'b0;
            drop      <= 1'b0;
            landed    <= 1'b0;
            cleared   <= 1'b0;
        end else begin
            state     <= state_n;
            frame_cnt <= frame_cnt_n;
            form_x    <= form_x_n;
            form_y    <= form_y_n;
            dir       <= dir_n;
            step      <= step_n;
            drop      <= drop_n;
            landed    <= landed_n;
            cleared   <= cleared_n;
        end
    end

    always_comb begin
        state_n     = state;
        frame_cnt_n = frame_cnt;
        form_x_n    = form_x;
        form_y_n    = form_y;
        dir_n       = dir;
        step_n      = 1'b0;
        drop_n      = 1'b0;
        landed_n    = landed;
        cleared_n   = cleared;

        unique case (state)
            IDLE: begin
                if (start) state_n = MARCH;
            end
            MARCH: begin
                // The clear check ignores enable so a dead wave is always noticed.
                if (tick) begin
                    if (!any_alive) begin
                        state_n   = CLEARED;
                        cleared_n = 1'b1;
                    end else if (enable) begin
                        if (cnt_inc >= period) begin
                            frame_cnt_n = '0;
                            if (want_drop) begin
                                form_y_n = new_y[9:0];
                                dir_n    = ~dir;
                                drop_n   = 1'b1;
                                if (will_land) begin
                                    state_n  = LANDED;
                                    landed_n = 1'b1;
                                end
                            end else begin
                                form_x_n = dir ? 10'(form_x + 10'(STEP_X))
                                               : 10'(form_x - 10'(STEP_X));
                                step_n   = 1'b1;
                            end
                        end else begin
                            frame_cnt_n = cnt_inc;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alien_march_controller.sv
// Directed bench for alien_march_controller with hand-computed positions.
module tb_alien_march_controller;

    logic       Pclk = 1'b0;
    logic       rst_n;
    logic [9:0] xx, yy;
    logic       start, enable;
    logic [7:0] col_alive;
    logic [9:0] form_x, form_y;
    logic       dir, step, drop, landed, cleared;

    int checks = 0;
    int errors = 0;

    alien_march_controller dut (
        .Pclk      (Pclk),
        .rst_n     (rst_n),
        .xx        (xx),
        .yy        (yy),
        .start     (start),
        .enable    (enable),
        .col_alive (col_alive),
        .form_x    (form_x),
        .form_y    (form_y),
        .dir       (dir),
        .step      (step),
        .drop      (drop),
        .landed    (landed),
        .cleared   (cleared)
    );

    always #5 Pclk = ~Pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_cycle();
        @(posedge Pclk);
        #1;
    endtask

    // One frame: the tick pixel for one cycle, then one ordinary cycle.
    task automatic tick(output logic s, output logic d);
        xx = 10'd639;
        yy = 10'd479;
        @(posedge Pclk);
        #1;
        s  = step;
        d  = drop;
        xx = 10'd0;
        yy = 10'd0;
        @(posedge Pclk);
        #1;
        if (s || d) begin
            check("step_drop_excl", 32'(s & d), 32'd0);
            check("pulse_width", 32'({step, drop}), 32'd0);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        idle_cycle();
        start = 1'b0;
    endtask

    task automatic run_to_drop(input int budget, output int nsteps, output int nticks);
        logic s, d;
        bit   seen;
        nsteps = 0;
        nticks = 0;
        seen   = 1'b0;
        while (!seen && nticks < budget) begin
            tick(s, d);
            nticks++;
            if (s) nsteps++;
            if (d) seen = 1'b1;
        end
        check("drop_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        logic s, d;
        int   ns, nt, nsteps_dis;
        logic [9:0] hold_x, hold_y;

        rst_n = 1'b0; xx = '0; yy = '0; start = 1'b0; enable = 1'b1;
        col_alive = 8'hFF;
        repeat (3) idle_cycle();
        check("rst_form_x", 32'(form_x), 32'd135);
        check("rst_form_y", 32'(form_y), 32'd120);
        check("rst_dir", 32'(dir), 32'd1);
        check("rst_flags", 32'({step, drop, landed, cleared}), 32'd0);
        rst_n = 1'b1;

        // Ticks in IDLE do nothing until start.
        tick(s, d);
        check("idle_no_step", 32'(s), 32'd0);
        check("idle_form_x", 32'(form_x), 32'd135);
        pulse_start();

        // All columns alive: period 18.
        for (int i = 0; i < 17; i++) tick(s, d);
        check("pre_step_x", 32'(form_x), 32'd135);
        tick(s, d);
        check("first_step", 32'(s), 32'd1);
        check("first_step_x", 32'(form_x), 32'd139);
        run_to_drop(2000, ns, nt);
        check("full_steps", 32'(ns), 32'd46);
        check("full_ticks", 32'(nt), 32'd846);
        check("drop1_x", 32'(form_x), 32'd323);
        check("drop1_y", 32'(form_y), 32'd136);
        check("drop1_dir", 32'(dir), 32'd0);

        // Single column left: period 4, drop at form_x 7.
        col_alive = 8'h01;
        run_to_drop(2000, ns, nt);
        check("c1_steps", 32'(ns), 32'd79);
        check("c1_ticks", 32'(nt), 32'd320);
        check("c1_x", 32'(form_x), 32'd7);
        check("c1_y", 32'(form_y), 32'd152);
        check("c1_dir", 32'(dir), 32'd1);

        // Four columns: period 10, right edge form_x+151.
        col_alive = 8'h0F;
        run_to_drop(3000, ns, nt);
        check("c4_steps", 32'(ns), 32'd119);
        check("c4_ticks", 32'(nt), 32'd1200);
        check("c4_x", 32'(form_x), 32'd483);
        check("c4_y", 32'(form_y), 32'd168);
        check("c4_dir", 32'(dir), 32'd0);

        // Mid-interval kill: count 5 already exceeds the new period 4.
        col_alive = 8'hFF;
        for (int i = 0; i < 5; i++) tick(s, d);
        check("mid_hold_x", 32'(form_x), 32'd483);
        col_alive = 8'h01;
        tick(s, d);
        check("mid_kill_step", 32'(s), 32'd1);
        check("mid_kill_x", 32'(form_x), 32'd479);

        // Pause: counter must hold at 0 across disabled ticks.
        enable = 1'b0;
        nsteps_dis = 0;
        for (int i = 0; i < 30; i++) begin
            tick(s, d);
            if (s || d) nsteps_dis++;
        end
        check("pause_moves", 32'(nsteps_dis), 32'd0);
        check("pause_x", 32'(form_x), 32'd479);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) tick(s, d);
        check("resume_x_hold", 32'(form_x), 32'd479);
        tick(s, d);
        check("resume_step", 32'(s), 32'd1);
        check("resume_x", 32'(form_x), 32'd475);

        // Reset mid-march, with the tick pixel present on the reset edge.
        xx = 10'd639; yy = 10'd479; rst_n = 1'b0;
        idle_cycle();
        xx = 10'd0; yy = 10'd0; rst_n = 1'b1;
        check("mrst_x", 32'(form_x), 32'd135);
        check("mrst_y", 32'(form_y), 32'd120);
        check("mrst_dir", 32'(dir), 32'd1);
        check("mrst_flags", 32'({step, drop, landed, cleared}), 32'd0);

        // Landing: cols 0 and 7 (period 6); lands once form_y+100 >= 440.
        col_alive = 8'h81;
        pulse_start();
        for (int k = 1; k <= 14; k++) begin
            run_to_drop(2000, ns, nt);
            check("land_y", 32'(form_y), 32'(120 + 16 * k));
            check("land_flag", 32'(landed), 32'(k == 14));
        end
        hold_x = form_x;
        hold_y = form_y;
        for (int i = 0; i < 8; i++) tick(s, d);
        pulse_start();
        tick(s, d);
        check("landed_frz_x", 32'(form_x), 32'(hold_x));
        check("landed_frz_y", 32'(form_y), 32'(hold_y));
        check("landed_no_step", 32'({s, d}), 32'd0);
        check("landed_sticky", 32'(landed), 32'd1);

        // Wave clear on the tick where a step would be due.
        rst_n = 1'b0;
        idle_cycle();
        rst_n = 1'b1;
        col_alive = 8'h01;
        pulse_start();
        for (int i = 0; i < 3; i++) tick(s, d);
        col_alive = 8'h00;
        tick(s, d);
        check("clr_flag", 32'(cleared), 32'd1);
        check("clr_no_step", 32'(s), 32'd0);
        check("clr_x", 32'(form_x), 32'd135);
        col_alive = 8'h01;
        pulse_start();
        for (int i = 0; i < 5; i++) tick(s, d);
        check("clr_frz_x", 32'(form_x), 32'd135);
        check("clr_sticky", 32'({landed, cleared}), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
